// File: rtl/booth_iter_counter_if.sv
// Control/status bundle between the multiplier controller and the Booth iteration counter.
// The master drives the strobes and limit; the slave (counter) returns count and status.
interface booth_iter_counter_if #(
  parameter int unsigned WIDTH  = 3,
  parameter int unsigned PASS_W = 4
);
  logic              init;
  logic              cnt;
  logic              load_limit;
  logic [WIDTH-1:0]  limit_in;
  logic              mode_reload;
  logic [WIDTH-1:0]  count;
  logic              cnt_done;
  logic              done_pulse;
  logic [PASS_W-1:0] passes;
  logic              busy;

  modport master (
    output init, cnt, load_limit, limit_in, mode_reload,
    input  count, cnt_done, done_pulse, passes, busy
  );

  modport slave (
    input  init, cnt, load_limit, limit_in, mode_reload,
    output count, cnt_done, done_pulse, passes, busy
  );
endinterface

// File: rtl/booth_iter_counter.sv
// Iteration counter sequencing the Booth datapath: counts cnt strobes up to a programmable limit,
// with one-shot or auto-reload behaviour and a saturating count of completed passes.
module booth_iter_counter #(
  parameter int unsigned WIDTH         = 3,
  parameter int unsigned DEFAULT_LIMIT = 4,
  parameter int unsigned PASS_W        = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  booth_iter_counter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic [WIDTH-1:0]  limit_q, limit_d;
  logic              mode_q, mode_d;
  logic [PASS_W-1:0] passes_q, passes_d;
  logic              pulse_q, pulse_d;

  logic [WIDTH-1:0]  count_nxt;
  logic [PASS_W-1:0] passes_sat;

  assign count_nxt  = count_q + WIDTH'(1);
  assign passes_sat = (&passes_q) ? passes_q : passes_q + PASS_W'(1);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    limit_d  = limit_q;
    mode_d   = mode_q;
    passes_d = passes_q;
    pulse_d  = 1'b0;

    // Limit is frozen while running; a same-cycle init sees the freshly loaded value.
    if (bus.load_limit && (state_q != StRun)) begin
      limit_d = bus.limit_in;
    end

    if (bus.init) begin
      count_d  = '0;
      passes_d = '0;
      mode_d   = bus.mode_reload;
      if (limit_d == '0) begin
        state_d  = StDone;
        pulse_d  = 1'b1;
        passes_d = PASS_W'(1);
      end else begin
        state_d = StRun;
      end
    end else if (bus.cnt && (state_q == StRun)) begin
      if (count_nxt == limit_q) begin
        pulse_d  = 1'b1;
        passes_d = passes_sat;
        if (mode_q) begin
          count_d = '0;
        end else begin
          count_d = limit_q;
          state_d = StDone;
        end
      end else begin
        count_d = count_nxt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      count_q  <= '0;
      limit_q  <= WIDTH'(DEFAULT_LIMIT);
      mode_q   <= 1'b0;
      passes_q <= '0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      limit_q  <= limit_d;
      mode_q   <= mode_d;
      passes_q <= passes_d;
      pulse_q  <= pulse_d;
    end
  end

  assign bus.count      = count_q;
  assign bus.passes     = passes_q;
  assign bus.done_pulse = pulse_q;
  assign bus.cnt_done   = (state_q == StDone);
  assign bus.busy       = (state_q == StRun);

endmodule

// File: tb/tb_booth_iter_counter.sv
// Self-checking bench for booth_iter_counter: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_booth_iter_counter;

  localparam int unsigned WIDTH  = 3;
  localparam int unsigned PASS_W = 4;
  localparam int PASS_MAX = (1 << PASS_W) - 1;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  bit   chk_en;

  booth_iter_counter_if #(.WIDTH(WIDTH), .PASS_W(PASS_W)) bus ();

  booth_iter_counter #(
    .WIDTH        (WIDTH),
    .DEFAULT_LIMIT(4),
    .PASS_W       (PASS_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: plain integers and flags describing the counter's observable contract.
  int m_count, m_limit, m_passes;
  bit m_run, m_done, m_pulse, m_mode;

  always @(posedge clk or posedge rst) begin
    int eff, c, p;
    bit run, done, pulse, mode;
    if (rst) begin
      m_count  <= 0;
      m_limit  <= 4;
      m_passes <= 0;
      m_run    <= 1'b0;
      m_done   <= 1'b0;
      m_pulse  <= 1'b0;
      m_mode   <= 1'b0;
    end else begin
      eff = (bus.load_limit && !m_run) ? int'(bus.limit_in) : m_limit;
      c = m_count; p = m_passes; run = m_run; done = m_done; mode = m_mode; pulse = 1'b0;
      if (bus.init) begin
        c = 0;
        mode = bus.mode_reload;
        if (eff == 0) begin
          run = 0; done = 1; pulse = 1; p = 1;
        end else begin
          run = 1; done = 0; p = 0;
        end
      end else if (bus.cnt && m_run) begin
        if (m_count + 1 == m_limit) begin
          pulse = 1;
          p = (m_passes + 1 > PASS_MAX) ? PASS_MAX : m_passes + 1;
          if (m_mode) c = 0;
          else begin
            c = m_limit; run = 0; done = 1;
          end
        end else begin
          c = m_count + 1;
        end
      end
      m_count  <= c;
      m_limit  <= eff;
      m_passes <= p;
      m_run    <= run;
      m_done   <= done;
      m_pulse  <= pulse;
      m_mode   <= mode;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model.count",      int'(bus.count),      m_count);
      check("model.cnt_done",   int'(bus.cnt_done),   int'(m_done));
      check("model.done_pulse", int'(bus.done_pulse), int'(m_pulse));
      check("model.passes",     int'(bus.passes),     m_passes);
      check("model.busy",       int'(bus.busy),       int'(m_run));
    end
  end

  // Literal expectation: pins both the DUT and the model.
  task automatic lit(input string name, input int dut_v, input int mdl_v, input int exp);
    check({name, ".dut"}, dut_v, exp);
    check({name, ".model"}, mdl_v, exp);
  endtask

  // Apply inputs for one clock edge; returns at the following negedge.
  task automatic step(input bit i, input bit c, input bit l, input int li, input bit m);
    bus.init        = i;
    bus.cnt         = c;
    bus.load_limit  = l;
    bus.limit_in    = WIDTH'(li);
    bus.mode_reload = m;
    @(negedge clk);
  endtask

  initial begin
    int exp_seq[7];
    n_tests = 0; n_fail = 0; chk_en = 1'b0;
    bus.init = 0; bus.cnt = 0; bus.load_limit = 0; bus.limit_in = '0; bus.mode_reload = 0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    lit("reset.count", int'(bus.count), m_count, 0);
    lit("reset.busy", int'(bus.busy), int'(m_run), 0);
    lit("reset.passes", int'(bus.passes), m_passes, 0);

    // 1: default limit, one-shot
    step(1, 0, 0, 0, 0);
    lit("t1.busy", int'(bus.busy), int'(m_run), 1);
    for (int k = 1; k <= 4; k++) begin
      step(0, 1, 0, 0, 0);
      lit("t1.count", int'(bus.count), m_count, k);
      lit("t1.cnt_done", int'(bus.cnt_done), int'(m_done), (k == 4) ? 1 : 0);
      lit("t1.pulse", int'(bus.done_pulse), int'(m_pulse), (k == 4) ? 1 : 0);
    end
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    lit("t1.hold_count", int'(bus.count), m_count, 4);
    lit("t1.passes", int'(bus.passes), m_passes, 1);
    lit("t1.pulse_off", int'(bus.done_pulse), int'(m_pulse), 0);

    // 2: reload mode, limit 3
    step(0, 0, 1, 3, 0);
    step(1, 0, 0, 0, 1);
    exp_seq = '{1, 2, 0, 1, 2, 0, 1};
    for (int k = 0; k < 7; k++) begin
      step(0, 1, 0, 0, 0);
      lit("t2.count", int'(bus.count), m_count, exp_seq[k]);
      lit("t2.pulse", int'(bus.done_pulse), int'(m_pulse), (k == 2 || k == 5) ? 1 : 0);
      lit("t2.cnt_done", int'(bus.cnt_done), int'(m_done), 0);
      lit("t2.busy", int'(bus.busy), int'(m_run), 1);
    end
    lit("t2.passes", int'(bus.passes), m_passes, 2);

    // 3: limit 0 and limit 7
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 0);
    lit("t3.done3", int'(bus.cnt_done), int'(m_done), 1);
    step(1, 0, 1, 0, 1);
    lit("t3.lim0_done", int'(bus.cnt_done), int'(m_done), 1);
    lit("t3.lim0_pulse", int'(bus.done_pulse), int'(m_pulse), 1);
    lit("t3.lim0_passes", int'(bus.passes), m_passes, 1);
    step(0, 0, 1, 7, 0);
    step(1, 0, 0, 0, 0);
    for (int k = 1; k <= 7; k++) begin
      step(0, 1, 0, 0, 0);
      lit("t3.lim7_done", int'(bus.cnt_done), int'(m_done), (k == 7) ? 1 : 0);
    end
    lit("t3.lim7_count", int'(bus.count), m_count, 7);

    // 4: priority and ignore rules
    step(1, 0, 1, 3, 0);
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    lit("t4.init_wins", int'(bus.count), m_count, 0);
    step(0, 1, 1, 5, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    lit("t4.old_limit_done", int'(bus.cnt_done), int'(m_done), 1);
    lit("t4.old_limit_count", int'(bus.count), m_count, 3);
    step(1, 0, 1, 5, 0);
    for (int k = 1; k <= 5; k++) step(0, 1, 0, 0, 0);
    lit("t4.new_limit_done", int'(bus.cnt_done), int'(m_done), 1);
    lit("t4.new_limit_count", int'(bus.count), m_count, 5);

    // 5: async reset mid-run
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    lit("t5.pre_count", int'(bus.count), m_count, 2);
    #2 rst = 1'b1;
    #1;
    check("t5.async_count", int'(bus.count), 0);
    check("t5.async_busy", int'(bus.busy), 0);
    check("t5.async_passes", int'(bus.passes), 0);
    check("t5.async_done", int'(bus.cnt_done), 0);
    @(negedge clk);
    rst = 1'b0;
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    lit("t5.ignored_count", int'(bus.count), m_count, 0);
    step(1, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) step(0, 1, 0, 0, 0);
    lit("t5.default_limit", int'(bus.cnt_done), int'(m_done), 1);
    lit("t5.default_count", int'(bus.count), m_count, 4);

    // 6: saturation with limit 1 reload
    step(0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 1);
    for (int k = 1; k <= PASS_MAX + 4; k++) begin
      step(0, 1, 0, 0, 0);
      lit("t6.passes", int'(bus.passes), m_passes, (k > PASS_MAX) ? PASS_MAX : k);
      lit("t6.pulse", int'(bus.done_pulse), int'(m_pulse), 1);
    end

    // Randomized traffic, checked by the per-cycle compare process
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      step(($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1,
           ($urandom_range(0, 4) == 0), int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_iter_counter.md
Name: booth_iter_counter

Overview:
- Parametrised iteration counter that sequences the Booth multiplier datapath.
- Counts `cnt` strobes from 0 up to a programmable terminal value `limit`, then flags completion.
- Supports one-shot mode (stop in DONE) and auto-reload mode (wrap and keep counting), and counts completed passes.
- Sits between the multiplier controller FSM (drives `init` and `cnt`) and the datapath step logic.

Parameters:
- WIDTH, 3, width of `count`, `limit_in` and the limit register; legal limit range is 0..2^WIDTH-1.
- DEFAULT_LIMIT, 4, value loaded into the limit register on reset; must fit in WIDTH bits.
- PASS_W, 4, width of the `passes` counter.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- init  in  1  synchronous clear-and-arm: zero `count`, sample `mode_reload`, enter RUN.
- cnt  in  1  increment strobe, honoured only in RUN.
- load_limit  in  1  load `limit_in` into the limit register; honoured only in IDLE or DONE.
- limit_in  in  WIDTH  new terminal count.
- mode_reload  in  1  0 = one-shot, 1 = auto-reload; sampled only when `init` is accepted.
- count  out  WIDTH  current count value.
- cnt_done  out  1  registered level, high exactly while the FSM is in DONE.
- done_pulse  out  1  registered 1-cycle pulse on every terminal event.
- passes  out  PASS_W  number of terminal events since the last `init`; saturates at all-ones.
- busy  out  1  high while in RUN.

Behaviour:

Reset (async, on `rst` high):
- state = IDLE, count = 0, limit = DEFAULT_LIMIT, mode_q = 0, passes = 0.
- cnt_done = 0, done_pulse = 0, busy = 0.
- Reset asserted mid-RUN aborts immediately; there is no partial-completion indication.

All outputs are registers; no combinational input-to-output paths.

States:
- IDLE: count holds at 0; `cnt` ignored; `load_limit` honoured.
- RUN: busy = 1; `load_limit` ignored (limit is frozen for the run).
- DONE: cnt_done = 1; count holds at `limit`; `cnt` ignored; `load_limit` honoured.

Priority per cycle: `init` > `cnt`. `load_limit` is independent of both. When `load_limit` and `init` are asserted in the same IDLE/DONE cycle, the run uses the newly loaded limit (the next-limit value is used for the comparison).

`init` (accepted from any state, including RUN, where it restarts the run):
- count <= 0, passes <= 0, mode_q <= `mode_reload`.
- If the effective limit is nonzero: state <= RUN.
- If the effective limit is 0: state <= DONE, done_pulse <= 1, passes <= 1. `mode_q` is irrelevant in this case.

`cnt` in RUN (when `init` is not asserted), with nxt = count + 1 (WIDTH bits):
- nxt != limit: count <= nxt.
- nxt == limit and mode_q = 0: count <= limit, state <= DONE, done_pulse <= 1, passes increments.
  - cnt_done rises on the same edge that count reaches limit; there is no extra lag cycle.
- nxt == limit and mode_q = 1: count <= 0, state stays RUN, done_pulse <= 1, passes increments.
- limit = 2^WIDTH-1 is legal. The comparison is exact, so no wrap occurs before the terminal value.

`passes`:
- Saturates at 2^PASS_W-1 and never wraps.

`done_pulse`:
- Deasserts on the next edge unless another terminal event occurs.
- In reload mode with limit = 1 and `cnt` held high, done_pulse stays high continuously, and passes increments every cycle until saturation.

Test Plan:
1. Default limit, one-shot: reset, `init`, then `cnt` high for 4 cycles -> count 1,2,3,4; cnt_done and done_pulse rise on the 4th edge; further `cnt` pulses leave count = 4 and passes = 1.
2. Reload mode: `load_limit` with limit_in = 3, `init` with mode_reload = 1, 7 `cnt` cycles -> count 1,2,0,1,2,0,1; done_pulse on the 3rd and 6th edges; passes = 2; cnt_done stays 0; busy stays 1.
3. Limit 0 and limit 7 (WIDTH = 3): limit 0 + `init` -> DONE next edge with done_pulse = 1 and passes = 1; limit 7 -> DONE exactly after 7 `cnt` pulses with count = 7.
4. Priority and ignore rules:
   - `init` and `cnt` in the same RUN cycle -> count = 0.
   - `load_limit` of 5 during RUN -> ignored; completion still occurs at the old limit.
   - `load_limit` of 5 together with `init` in DONE -> the next run ends at 5.
5. Async reset mid-run: assert `rst` between clock edges at count = 2 -> all outputs are 0 immediately and limit returns to 4; `cnt` after reset release has no effect until `init`.
6. Saturation (PASS_W = 2): reload mode, limit 1, `cnt` held for 6 cycles -> passes goes 1,2,3,3,3,3.
